// File: rtl/usb_tx_nrzi_stuffer.sv
// -----------------------------------------------------------------------------
// usb_tx_nrzi_stuffer
//
// Transmit line stage of the USB controller. It takes the LSB-first serial
// bitstream from the packet shifter at one bit per clock. It inserts stuffed
// bits, NRZI-encodes the result, appends the EOP and drives the full-speed
// differential pair.
//
// Handshake: a bit transfers on a rising clock edge where bit_valid & bit_ready
// are both high. bit_ready depends only on the FSM state, never on bit_valid.
// bit_in and last_bit are only looked at on a transfer cycle. If bit_valid is
// low while bit_ready is high, the packet ends early: an EOP is emitted and
// underrun is flagged.
//
// Line timing: dp/dm are registered and follow the state by one cycle.
// done/underrun are registered in the same way, so they pulse together with
// the final J level on the line.
//
// Ports:
//   clock      system clock, one bit time per cycle
//   reset_n    asynchronous active-low reset
//   start      one-cycle packet start pulse (ignored while busy)
//   bit_in     serial data bit from the shifter
//   bit_valid  bit_in is valid this cycle
//   last_bit   bit_in is the final packet bit
//   bit_ready  bit accepted this cycle (low in stuff/EOP/idle cycles)
//   dp, dm     registered D+/D- line levels
//   busy       packet in progress, until the cycle after the final J
//   done       one-cycle pulse with the final J on the line
//   underrun   pulses with done when the packet was aborted
//   state_dbg  current FSM state for observation
// -----------------------------------------------------------------------------
module usb_tx_nrzi_stuffer #(
    parameter int STUFF_LEN      = 6,
    parameter int EOP_SE0_CYCLES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       bit_in,
    input  logic       bit_valid,
    input  logic       last_bit,
    output logic       bit_ready,
    output logic       dp,
    output logic       dm,
    output logic       busy,
    output logic       done,
    output logic       underrun,
    output logic [2:0] state_dbg
);

    localparam int OW = $clog2(STUFF_LEN + 1);
    localparam int SW = $clog2(EOP_SE0_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        STUFF   = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } state_t;

    state_t        state, state_next;
    logic          level;        // current NRZI level, 1 = J
    logic          level_next;   // level after the bit presented this cycle
    logic [OW-1:0] ones_cnt;
    logic [SW-1:0] se0_cnt;
    logic          abort_flag;
    logic          stuff_last;   // the bit that triggered the stuff was last

    assign bit_ready  = (state == SEND);
    assign busy       = (state != IDLE) || done;
    assign state_dbg  = state;
    // NRZI encoding: a 0 toggles the line and a 1 holds it.
    assign level_next = bit_in ? level : ~level;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = SEND;
            end
            SEND: begin
                if (!bit_valid) begin
                    state_next = EOP_SE0;
                end else if (bit_in && (ones_cnt == OW'(STUFF_LEN - 1))) begin
                    // The stuff bit goes out before any EOP, even on the last bit.
                    state_next = STUFF;
                end else if (last_bit) begin
                    state_next = EOP_SE0;
                end
            end
            STUFF: begin
                state_next = stuff_last ? EOP_SE0 : SEND;
            end
            EOP_SE0: begin
                if (se0_cnt == SW'(EOP_SE0_CYCLES - 1)) state_next = EOP_J;
            end
            EOP_J: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: NRZI level, line registers, counters and status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level      <= 1'b1;
            dp         <= 1'b1;
            dm         <= 1'b0;
            ones_cnt   <= '0;
            se0_cnt    <= '0;
            abort_flag <= 1'b0;
            stuff_last <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            case (state)
                IDLE: begin
                    level      <= 1'b1;
                    dp         <= 1'b1;
                    dm         <= 1'b0;
                    ones_cnt   <= '0;
                    se0_cnt    <= '0;
                    abort_flag <= 1'b0;
                    stuff_last <= 1'b0;
                end
                SEND: begin
                    if (bit_valid) begin
                        level      <= level_next;
                        dp         <= level_next;
                        dm         <= ~level_next;
                        ones_cnt   <= bit_in ? (ones_cnt + OW'(1)) : '0;
                        stuff_last <= last_bit;
                    end else begin
                        // The line holds its level for this cycle. SE0 follows.
                        abort_flag <= 1'b1;
                    end
                end
                STUFF: begin
                    level    <= ~level;
                    dp       <= ~level;
                    dm       <= level;
                    ones_cnt <= '0;
                end
                EOP_SE0: begin
                    dp      <= 1'b0;
                    dm      <= 1'b0;
                    se0_cnt <= (se0_cnt == SW'(EOP_SE0_CYCLES - 1)) ? '0 : (se0_cnt + SW'(1));
                end
                EOP_J: begin
                    level      <= 1'b1;
                    dp         <= 1'b1;
                    dm         <= 1'b0;
                    done       <= 1'b1;
                    underrun   <= abort_flag;
                    abort_flag <= 1'b0;
                    se0_cnt    <= '0;
                end
                default: begin
                    level <= 1'b1;
                    dp    <= 1'b1;
                    dm    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_nrzi_stuffer.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_nrzi_stuffer
//
// Directed bench for usb_tx_nrzi_stuffer. A small shifter model presents bits
// and advances only on bit_valid & bit_ready. Each packet step compares the
// line, done, underrun, busy and bit_ready against hand-computed sequences.
// Trace index k counts sampled cycles after the edge that latched start.
// -----------------------------------------------------------------------------
module tb_usb_tx_nrzi_stuffer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       last_bit;
    logic       bit_ready;
    logic       dp;
    logic       dm;
    logic       busy;
    logic       done;
    logic       underrun;
    logic [2:0] state_dbg;

    int compared   = 0;
    int mismatched = 0;

    logic       bits_q[$];
    logic [1:0] exp_q[$];        // expected {dp,dm} per trace cycle
    logic       exp_ready_q[$];  // expected bit_ready per trace cycle

    usb_tx_nrzi_stuffer #(
        .STUFF_LEN      (6),
        .EOP_SE0_CYCLES (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .last_bit  (last_bit),
        .bit_ready (bit_ready),
        .dp        (dp),
        .dm        (dm),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Runs one packet from bits_q. The trace must match exp_q. done and
    // underrun are expected only at the last-but-one trace cycle, and busy
    // is expected low only at the last one.
    task automatic run_pkt(input string name, input int drop_after, input int start_k,
                           input logic exp_under, input int exp_shifts);
        int   n;
        int   len;
        int   idx;
        int   dones;
        logic acc;
        n     = bits_q.size();
        len   = exp_q.size();
        idx   = 0;
        dones = 0;
        acc   = 1'b0;
        start     = 1'b1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        last_bit  = 1'b0;
        for (int k = 1; k <= len; k++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (acc) idx++;
            if (done) dones++;
            check({name, " line"},     k, 32'({dp, dm}),        32'(exp_q[k-1]));
            check({name, " done"},     k, 32'(done),            32'(k == len - 1));
            check({name, " underrun"}, k, 32'(underrun),        32'((k == len - 1) && exp_under));
            check({name, " busy"},     k, 32'(busy),            32'(k < len));
            if (k <= exp_ready_q.size())
                check({name, " ready"}, k, 32'(bit_ready), 32'(exp_ready_q[k-1]));
            // Drive for the next edge.
            start = (k == start_k);
            if (idx < n && idx < drop_after) begin
                bit_valid = 1'b1;
                bit_in    = bits_q[idx];
                last_bit  = (idx == n - 1);
            end else begin
                bit_valid = 1'b0;
                bit_in    = 1'b0;
                last_bit  = 1'b0;
            end
            acc = bit_valid & bit_ready;
        end
        check({name, " shifts"},    0, 32'(idx),   32'(exp_shifts));
        check({name, " done_count"}, 0, 32'(dones), 32'(1));
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        last_bit  = 1'b0;
        start     = 1'b0;
    endtask

    initial begin
        // Reset values
        reset_n   = 1'b0;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        last_bit  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst dpdm",     0, 32'({dp, dm}),  32'(2'b10));
        check("rst busy",     0, 32'(busy),      32'(0));
        check("rst ready",    0, 32'(bit_ready), 32'(0));
        check("rst done",     0, 32'(done),      32'(0));
        check("rst underrun", 0, 32'(underrun),  32'(0));
        reset_n = 1'b1;

        // Reset mid-SEND, after a 0 has pulled the line to K
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; bit_valid = 1'b1; bit_in = 1'b0;
        @(posedge clock); #1;
        check("midrst pre dpdm", 0, 32'({dp, dm}), 32'(2'b01));
        reset_n = 1'b0;
        #1;
        check("midrst dpdm",  0, 32'({dp, dm}),  32'(2'b10));
        check("midrst busy",  0, 32'(busy),      32'(0));
        check("midrst ready", 0, 32'(bit_ready), 32'(0));
        @(posedge clock); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("postrst busy",  i, 32'(busy),      32'(0));
            check("postrst ready", i, 32'(bit_ready), 32'(0));
            check("postrst dpdm",  i, 32'({dp, dm}),  32'(2'b10));
        end
        bit_valid = 1'b0;

        // SYNC pattern
        bits_q      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_q       = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01,
                        2'b00, 2'b00, 2'b10, 2'b10};
        exp_ready_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        run_pkt("sync", 100, 0, 1'b0, 8);

        // Stuffing in mid packet: 0 then eight 1s
        bits_q      = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_q       = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                        2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10};
        exp_ready_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        run_pkt("stuff", 100, 0, 1'b0, 9);

        // Stuff triggered by the last bit: stuff toggle precedes SE0
        bits_q      = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_q       = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                        2'b00, 2'b00, 2'b10, 2'b10};
        exp_ready_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        run_pkt("stuff_end", 100, 0, 1'b0, 7);

        // A 0 resets the ones count: 1x5, 0, 1x5 never stuffs
        bits_q      = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_q       = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01,
                        2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10};
        exp_ready_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        run_pkt("no_stuff", 100, 0, 1'b0, 11);

        // Underrun after three accepted bits
        bits_q      = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_q       = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10};
        exp_ready_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        run_pkt("underrun", 3, 0, 1'b1, 3);

        // start pulsed mid-packet has no effect
        bits_q      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_q       = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01,
                        2'b00, 2'b00, 2'b10, 2'b10};
        exp_ready_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        run_pkt("start_busy", 100, 4, 1'b0, 8);

        // Idle after the last packet
        @(posedge clock); #1;
        check("final busy", 0, 32'(busy),     32'(0));
        check("final dpdm", 0, 32'({dp, dm}), 32'(2'b10));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/usb_tx_nrzi_stuffer.md
Name: usb_tx_nrzi_stuffer

Overview:
- Transmit line stage of the USB controller.
- Consumes the serial bitstream produced by the parallel-in/serial-out packet shifter, LSB-first, one bit per clock.
- Performs USB bit stuffing and NRZI encoding, then appends the EOP.
- Drives the full-speed differential pair (dp/dm) and back-pressures the shifter with bit_ready during stuffed-bit cycles.

Parameters:
- STUFF_LEN, 6: consecutive accepted 1s that force insertion of one stuffed 0.
- EOP_SE0_CYCLES, 2: SE0 cycles in the EOP before the final J cycle.

Ports:
- clock  input  1  system clock, one bit time per cycle
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse that begins a packet; ignored while busy
- bit_in  input  1  current serial data bit from the shifter
- bit_valid  input  1  bit_in holds a valid bit this cycle
- last_bit  input  1  bit_in is the final bit of the packet (qualified by bit_valid)
- bit_ready  output  1  bit accepted this cycle; the shifter shifts only on bit_valid & bit_ready
- dp  output  1  D+ line, registered
- dm  output  1  D- line, registered
- busy  output  1  high from the cycle after start until the cycle after the final J
- done  output  1  one-cycle pulse during the final J cycle of EOP
- underrun  output  1  one-cycle pulse, coincident with done, when a packet was aborted

Behaviour:
- Reset: async on reset_n low. State IDLE; dp=1, dm=0 (J); bit_ready=0; busy=0; done=0; underrun=0; ones counter=0; abort flag cleared. Reset mid-packet abandons the packet with no EOP.
- States: IDLE, SEND, STUFF, EOP_SE0, EOP_J.
- IDLE:
  - Line held at J.
  - start=1 -> SEND next cycle; ones counter cleared.
- SEND:
  - bit_ready = 1 (combinational from state).
  - If bit_valid=1, the bit is accepted. NRZI: a 0 toggles the line level, a 1 holds it. The new level is registered onto dp (dm = ~dp) and visible the next cycle; latency is accept-to-line 1 cycle.
  - An accepted 0 clears the ones counter; an accepted 1 increments it.
  - If the increment reaches STUFF_LEN -> STUFF, even when last_bit=1 (the stuff bit precedes the EOP).
  - Else, if last_bit=1 -> EOP_SE0. Else stay in SEND.
  - If bit_valid=0 (underrun) -> EOP_SE0 immediately, set the abort flag, no bit consumed.
- STUFF:
  - bit_ready = 0. Line toggles (stuffed 0); ones counter cleared.
  - Next state: EOP_SE0 if the bit that triggered the stuff had last_bit=1, else SEND.
- EOP_SE0:
  - dp=0, dm=0 for exactly EOP_SE0_CYCLES cycles, counted by an internal counter.
  - Then -> EOP_J.
- EOP_J:
  - dp=1, dm=0 for one cycle.
  - done=1 this cycle; underrun=1 also if the abort flag is set.
  - -> IDLE, clearing the flag. busy drops the following cycle.
- start asserted outside IDLE: ignored. start and bit_valid in the same IDLE cycle: the bit is not accepted.
- bit_in and last_bit are sampled only when bit_valid & bit_ready.
- The NRZI level register is forced to J on entry to IDLE, so every packet starts from J.

Test Plan:
- Reset: hold reset_n low mid-SEND -> same cycle dp=1, dm=0, busy=0, bit_ready=0. After release, stays IDLE with no start.
- SYNC: start, then bits 0,0,0,0,0,0,0,1 (last on the 8th) -> dp sequence 0,1,0,1,0,1,0,0. Then dp/dm = 00, 00, then 10 with done=1. busy=0 the next cycle.
- Stuffing: bits 0 then eight 1s (last on the final 1) -> dp = 0 then 0×6 then 1 (stuff cycle, bit_ready=0, shifter holds) then 1,1, then SE0×2, J. 13 line cycles total.
- Stuff at end: bits 0, 1×6 with last on the 6th 1 -> stuff toggle occurs before SE0. No stuff on the 7th cycle after a 0 resets the count (bits 1×5,0,1×5 -> no STUFF state entered).
- Underrun: drop bit_valid after 3 accepted bits -> immediate SE0×2, J. done=1 and underrun=1 in the J cycle; exactly 3 shifter shifts occurred.
- start during busy: pulse start mid-packet -> no effect on line sequence, done exactly once.
